// File: rtl/df_output_buffer.sv
// df_output_buffer: tail of the CFNP dataflow. Captures one frame of
// N_WORDS signed results (no backpressure on the capture side), then replays
// it over a valid/ready handshake with olast on the final word and a
// one-cycle done pulse once the frame has fully drained.
module df_output_buffer #(
   parameter int DATA_W  = 16,
   parameter int N_WORDS = 8,
   parameter int CNT_W   = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] x,
   input  logic                     x_valid,
   output logic signed [DATA_W-1:0] odata,
   output logic                     ovalid,
   input  logic                     oready,
   output logic                     olast,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow
);

   typedef enum logic [1:0] {IDLE, CAPTURE, SEND, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_WORDS - 1);

   state_t                   state, state_nxt;
   logic [CNT_W-1:0]         wr_cnt, wr_nxt;
   logic [CNT_W-1:0]         rd_cnt, rd_nxt;
   logic                     ov_nxt;
   logic                     mem_we;
   logic signed [DATA_W-1:0] mem [N_WORDS];

   // Control state: FSM, frame counters and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         wr_cnt   <= '0;
         rd_cnt   <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         wr_cnt   <= wr_nxt;
         rd_cnt   <= rd_nxt;
         overflow <= ov_nxt;
      end
   end

   // Next-state logic; rd_cnt always indexes the word currently presented.
   always_comb begin
      state_nxt = state;
      wr_nxt    = wr_cnt;
      rd_nxt    = rd_cnt;
      ov_nxt    = overflow;
      mem_we    = 1'b0;
      case (state)
         IDLE: begin
            // A word arriving together with start is not part of the frame.
            if (start) begin
               state_nxt = CAPTURE;
               wr_nxt    = '0;
               ov_nxt    = 1'b0;
            end
         end
         CAPTURE: begin
            if (x_valid) begin
               mem_we = 1'b1;
               if (wr_cnt == LAST) begin
                  state_nxt = SEND;
                  wr_nxt    = '0;
                  rd_nxt    = '0;
               end else begin
                  wr_nxt = wr_cnt + 1'b1;
               end
            end
         end
         SEND: begin
            if (x_valid) ov_nxt = 1'b1;
            if (ovalid && oready) begin
               if (olast) state_nxt = DONE;
               else       rd_nxt    = rd_cnt + 1'b1;
            end
         end
         DONE: begin
            if (x_valid) ov_nxt = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Frame storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_cnt] <= x;
   end

   // Registered output side. The first SEND cycle only loads word 0, so
   // ovalid rises one edge after the last capture and mem is never read
   // in the same cycle it is written.
   always_ff @(posedge clk) begin
      if (!rst) begin
         odata  <= '0;
         ovalid <= 1'b0;
         olast  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         busy <= (state_nxt != IDLE);
         done <= (state_nxt == DONE);
         if (state == SEND) begin
            if (!ovalid) begin
               odata  <= mem[rd_cnt];
               ovalid <= 1'b1;
               olast  <= (rd_cnt == LAST);
            end else if (oready) begin
               if (olast) begin
                  ovalid <= 1'b0;
                  olast  <= 1'b0;
               end else begin
                  odata <= mem[rd_nxt];
                  olast <= (rd_nxt == LAST);
               end
            end
         end
      end
   end

endmodule
